output_unit: RTL and testbench

- Transmit-side counterpart of the router input unit; one instance per router output port.
- Tracks downstream buffer credits, driven by switch-allocation decrements and by credit returns from the downstream input unit.
- Presents a credit-available flag to the switch arbiter.
- Registers the crossbar flit onto the link.
- Detects credit protocol violations and blocks further traffic until cleared.

---
 rtl/output_unit.sv | 149 ++++++++++++++
 tb/tb_output_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_unit.sv
// rtl/output_unit.sv - router output unit: downstream credit tracking, link flit register, protocol error detection
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   credit_decre        switch-allocation grant to this port (consumes one credit)
//   credit_inc          credit return pulse from the downstream input unit
//   credit_avail        at least one credit free and unit ACTIVE (to switch arbiter)
//   st_valid, st_data   crossbar flit for this port
//   out_data_valid,
//   out_data            registered link flit
//   err_clr             leaves ERROR and restores the credit/inflight counters
//   err_flag            bit0 credit underflow, bit1 credit overflow or orphan flit
//   stat_flits,
//   stat_stalls         statistics counters; live only when OUTPUT_UNIT_STATS_EN is defined
//
// Optional feature macro: OUTPUT_UNIT_STATS_EN

module output_unit #(
  parameter int BIT_WIDTH    = 32,
  parameter int CREDIT_DEPTH = 8,
  parameter int CREDIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 credit_decre,
  input  logic                 credit_inc,
  output logic                 credit_avail,
  input  logic                 st_valid,
  input  logic [BIT_WIDTH-1:0] st_data,
  output logic                 out_data_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  input  logic                 err_clr,
  output logic [1:0]           err_flag,
  output logic [31:0]          stat_flits,
  output logic [31:0]          stat_stalls
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  localparam logic [CREDIT_WIDTH-1:0] CNT_MAX  = CREDIT_WIDTH'(CREDIT_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CREDIT_WIDTH-1:0] CNT_ONE  = CREDIT_WIDTH'(1);

  state_t                  state;
  logic [CREDIT_WIDTH-1:0] credit_cnt;
  logic [CREDIT_WIDTH-1:0] inflight;

  logic                    underflow;
  logic                    overflow;
  logic                    orphan;
  logic [CREDIT_WIDTH-1:0] credit_cnt_next;
  logic [CREDIT_WIDTH-1:0] inflight_next;

  assign underflow = credit_decre && !credit_inc && (credit_cnt == CNT_ZERO);
  assign overflow  = credit_inc && !credit_decre && (credit_cnt == CNT_MAX);
  assign orphan    = st_valid && !credit_decre && (inflight == CNT_ZERO);

  // Saturating next values; the error cases above are exactly the held-at-limit cases.
  always_comb begin
    credit_cnt_next = credit_cnt;
    if (credit_decre && !credit_inc && credit_cnt != CNT_ZERO)
      credit_cnt_next = credit_cnt - CNT_ONE;
    else if (credit_inc && !credit_decre && credit_cnt != CNT_MAX)
      credit_cnt_next = credit_cnt + CNT_ONE;
  end

  always_comb begin
    inflight_next = inflight;
    if (credit_decre && !st_valid && inflight != CNT_MAX)
      inflight_next = inflight + CNT_ONE;
    else if (st_valid && !credit_decre && inflight != CNT_ZERO)
      inflight_next = inflight - CNT_ONE;
  end

  // Pure decode of registered state: a credit returned at edge t is visible to SA in cycle t+1.
  assign credit_avail = (state == S_ACTIVE) && (credit_cnt != CNT_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      credit_cnt <= CNT_MAX;
      inflight   <= CNT_ZERO;
      err_flag   <= 2'b00;
    end else begin
      case (state)
        S_INIT: begin
          state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          credit_cnt <= credit_cnt_next;
          inflight   <= inflight_next;
          if (underflow || overflow || orphan) begin
            state    <= S_ERROR;
            err_flag <= {overflow || orphan, underflow};
          end
        end
        S_ERROR: begin
          if (err_clr) begin
            state      <= S_ACTIVE;
            credit_cnt <= CNT_MAX;
            inflight   <= CNT_ZERO;
            err_flag   <= 2'b00;
          end else begin
            credit_cnt <= credit_cnt_next;
            inflight   <= inflight_next;
            err_flag   <= err_flag | {overflow || orphan, underflow};
          end
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  // Link register keeps forwarding in ERROR so a flit already granted is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data_valid <= 1'b0;
      out_data       <= '0;
    end else begin
      out_data_valid <= st_valid && (state != S_INIT);
      if (st_valid && state != S_INIT)
        out_data <= st_data;
    end
  end

`ifdef OUTPUT_UNIT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_flits  <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (out_data_valid && stat_flits != 32'hFFFF_FFFF)
        stat_flits <= stat_flits + 32'd1;
      if (state == S_ACTIVE && credit_cnt == CNT_ZERO && stat_stalls != 32'hFFFF_FFFF)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`else
  assign stat_flits  = 32'd0;
  assign stat_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_output_unit.sv
// tb/tb_output_unit.sv - directed self-checking bench for output_unit
module tb_output_unit;

  logic        clk;
  logic        rst;
  logic        credit_decre;
  logic        credit_inc;
  logic        credit_avail;
  logic        st_valid;
  logic [31:0] st_data;
  logic        out_data_valid;
  logic [31:0] out_data;
  logic        err_clr;
  logic [1:0]  err_flag;
  logic [31:0] stat_flits;
  logic [31:0] stat_stalls;

  int checks   = 0;
  int failures = 0;

  output_unit #(.BIT_WIDTH(32), .CREDIT_DEPTH(8), .CREDIT_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .credit_decre   (credit_decre),
    .credit_inc     (credit_inc),
    .credit_avail   (credit_avail),
    .st_valid       (st_valid),
    .st_data        (st_data),
    .out_data_valid (out_data_valid),
    .out_data       (out_data),
    .err_clr        (err_clr),
    .err_flag       (err_flag),
    .stat_flits     (stat_flits),
    .stat_stalls    (stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    credit_decre = 1'b0;
    credit_inc   = 1'b0;
    st_valid     = 1'b0;
    st_data      = 32'h0;
    err_clr      = 1'b0;
  endtask

  // Reset and release just after an edge; the next edge is the INIT -> ACTIVE edge.
  task automatic do_reset;
    idle_inputs();
    rst = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b0;
    #13;
    checks++;
    if ({credit_avail, out_data_valid, err_flag} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: avail=%b odv=%b err=%b, required all 0", credit_avail, out_data_valid, err_flag);
    end
    checks++;
    if ({out_data, stat_flits, stat_stalls} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: out=%h flits=%0d stalls=%0d, required 0", out_data, stat_flits, stat_stalls);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (credit_avail !== 1'b0) begin
      failures++;
      $display("FAIL init_avail: got %b required 0", credit_avail);
    end
    step();
    checks++;
    if (credit_avail !== 1'b1 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL active_avail: avail=%b err=%b required 1/00", credit_avail, err_flag);
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 8; i++) begin
      credit_decre = 1'b1;
      st_valid     = (i > 0);
      st_data      = 32'h10 + i - 1;
      step();
      checks++;
      if (credit_avail !== (i < 7)) begin
        failures++;
        $display("FAIL drain_avail[%0d]: got %b required %b", i, credit_avail, (i < 7));
      end
      if (i > 0) begin
        checks++;
        if (out_data_valid !== 1'b1 || out_data !== 32'h10 + i - 1) begin
          failures++;
          $display("FAIL drain_flit[%0d]: odv=%b data=%h required 1/%h", i, out_data_valid, out_data, 32'h10 + i - 1);
        end
      end
    end
    credit_decre = 1'b0;
    st_valid     = 1'b1;
    st_data      = 32'h17;
    step();
    checks++;
    if (out_data_valid !== 1'b1 || out_data !== 32'h17) begin
      failures++;
      $display("FAIL drain_last: odv=%b data=%h required 1/00000017", out_data_valid, out_data);
    end
    st_valid = 1'b0;
    step();
    checks++;
    if (out_data_valid !== 1'b0 || out_data !== 32'h17 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL drain_hold: odv=%b data=%h err=%b required 0/00000017/00", out_data_valid, out_data, err_flag);
    end
    checks++;
`ifdef OUTPUT_UNIT_STATS_EN
    if (stat_flits !== 32'd8 || stat_stalls !== 32'd2) begin
      failures++;
      $display("FAIL drain_stats: flits=%0d stalls=%0d required 8/2", stat_flits, stat_stalls);
    end
`else
    if (stat_flits !== 32'd0 || stat_stalls !== 32'd0) begin
      failures++;
      $display("FAIL drain_stats_off: flits=%0d stalls=%0d required 0/0", stat_flits, stat_stalls);
    end
`endif
  endtask

  // Entered with credit_cnt == 0 and inflight == 0.
  task automatic test_zero_boundary;
    credit_decre = 1'b1;
    credit_inc   = 1'b1;
    step();
    checks++;
    if (credit_avail !== 1'b0 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL both_at_zero: avail=%b err=%b required 0/00", credit_avail, err_flag);
    end
    credit_decre = 1'b0;
    step();
    checks++;
    if (credit_avail !== 1'b1 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL inc_at_zero: avail=%b err=%b required 1/00", credit_avail, err_flag);
    end
    credit_inc   = 1'b0;
    credit_decre = 1'b1;
    step();
    checks++;
    if (credit_avail !== 1'b0 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL back_to_zero: avail=%b err=%b required 0/00", credit_avail, err_flag);
    end
    step();
    checks++;
    if (credit_avail !== 1'b0 || err_flag !== 2'b01) begin
      failures++;
      $display("FAIL underflow: avail=%b err=%b required 0/01", credit_avail, err_flag);
    end
    credit_decre = 1'b0;
    err_clr      = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (credit_avail !== 1'b1 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL err_clr: avail=%b err=%b required 1/00", credit_avail, err_flag);
    end
    credit_decre = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 6) begin
        checks++;
        if (credit_avail !== 1'b1) begin
          failures++;
          $display("FAIL clr_cnt7: avail=%b required 1", credit_avail);
        end
      end
    end
    credit_decre = 1'b0;
    checks++;
    if (credit_avail !== 1'b0 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL clr_cnt8: avail=%b err=%b required 0/00", credit_avail, err_flag);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    step();
    credit_inc = 1'b1;
    step();
    credit_inc = 1'b0;
    checks++;
    if (err_flag !== 2'b10 || credit_avail !== 1'b0) begin
      failures++;
      $display("FAIL overflow: err=%b avail=%b required 10/0", err_flag, credit_avail);
    end
  endtask

  task automatic test_orphan;
    do_reset();
    step();
    st_valid = 1'b1;
    st_data  = 32'h5A;
    step();
    st_valid = 1'b0;
    checks++;
    if (err_flag !== 2'b10 || credit_avail !== 1'b0) begin
      failures++;
      $display("FAIL orphan: err=%b avail=%b required 10/0", err_flag, credit_avail);
    end
    checks++;
    if (out_data_valid !== 1'b1 || out_data !== 32'h5A) begin
      failures++;
      $display("FAIL orphan_fwd: odv=%b data=%h required 1/0000005a", out_data_valid, out_data);
    end
  endtask

  task automatic test_midstream_reset;
    do_reset();
    step();
    credit_decre = 1'b1;
    repeat (5) step();
    credit_decre = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1;
      st_data  = 32'hA0 + k;
      step();
    end
    checks++;
    if (credit_avail !== 1'b1 || err_flag !== 2'b00 || out_data !== 32'hA2) begin
      failures++;
      $display("FAIL pre_rst: avail=%b err=%b data=%h required 1/00/000000a2", credit_avail, err_flag, out_data);
    end
    st_data      = 32'hFF;
    credit_decre = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({credit_avail, out_data_valid, err_flag} !== 4'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL async_rst: avail=%b odv=%b err=%b data=%h required 0", credit_avail, out_data_valid, err_flag, out_data);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (credit_avail !== 1'b0) begin
      failures++;
      $display("FAIL rst_init: avail=%b required 0", credit_avail);
    end
    step();
    credit_decre = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (credit_avail !== 1'b1) begin
        failures++;
        $display("FAIL rst_cnt[%0d]: avail=%b required 1", i, credit_avail);
      end
      step();
    end
    credit_decre = 1'b0;
    checks++;
    if (credit_avail !== 1'b0 || err_flag !== 2'b00) begin
      failures++;
      $display("FAIL rst_cnt_end: avail=%b err=%b required 0/00", credit_avail, err_flag);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_zero_boundary();
    test_overflow();
    test_orphan();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
